i2c_scl_timing_gen: RTL and testbench

//  Parametrised successor to the I2C core clock divider. Produces the SCL waveform and quarter-period

---
 rtl/i2c_pkg.sv | 43 ++++
 rtl/i2c_sync2.sv | 42 ++++
 rtl/i2c_scl_timing_gen.sv | 197 +++++++++++++++++++
 tb/tb_i2c_scl_timing_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared encodings and default divider constants for the I2C SCL
//            timing generator.
//            - FREQ_MODE_* : freq_mode table-select encodings
//            - PHASE_*     : quarter-period phase encodings
//            - state_e     : generator FSM states
//            - DEF_DIV_*   : default quarter reload values (50 MHz sys clock)
// Options  : none (I2C_CLK_STRETCH_EN is consumed by the top level)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  // freq_mode table-select encodings
  localparam logic [1:0] FREQ_MODE_100K = 2'b00;
  localparam logic [1:0] FREQ_MODE_400K = 2'b01;
  localparam logic [1:0] FREQ_MODE_1M   = 2'b10;
  localparam logic [1:0] FREQ_MODE_3M   = 2'b11;

  // Quarter-period phases: LOW0/LOW1 drive SCL low, HIGH0/HIGH1 release it
  localparam logic [1:0] PHASE_LOW0  = 2'd0;
  localparam logic [1:0] PHASE_LOW1  = 2'd1;
  localparam logic [1:0] PHASE_HIGH0 = 2'd2;
  localparam logic [1:0] PHASE_HIGH1 = 2'd3;

  // Generator states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Default quarter reload values (quarter length = reload + 1 cycles)
  localparam int unsigned DEF_DIV_MODE0 = 124;
  localparam int unsigned DEF_DIV_MODE1 = 30;
  localparam int unsigned DEF_DIV_MODE2 = 11;
  localparam int unsigned DEF_DIV_MODE3 = 3;

endpackage : i2c_pkg

`default_nettype wire

// File: rtl/i2c_sync2.sv
// ============================================================================
// Module   : i2c_sync2
// Purpose  : Two-flop synchroniser for the sampled SCL pad level. Resets to 1
//            so a released (high) bus is assumed until the pad is observed.
// Ports    : clk   in  1  system clock
//            reset in  1  synchronous, active-low reset
//            d     in  1  asynchronous input level
//            q     out 1  synchronised level
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_sync2
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule : i2c_sync2

`default_nettype wire

// File: rtl/i2c_scl_timing_gen.sv
// ============================================================================
// Module   : i2c_scl_timing_gen
// Purpose  : Generates the SCL waveform and quarter-period phase strobes for
//            the I2C bit engine. Quarter reload comes from a freq_mode table
//            or a runtime override; any change is applied only on the phase 3
//            tick so a period is never altered mid-way.
// Ports    : clk        in  1      system clock
//            reset      in  1      synchronous, active-low reset
//            enable     in  1      run request (level)
//            freq_mode  in  2      table select, sampled at period boundary
//            div_load   in  1      pulse: latch div_value as pending override
//            div_clr    in  1      pulse: drop override (div_load wins)
//            div_value  in  CNT_W  override quarter reload (0 clamps to 1)
//            scl_in     in  1      SCL pad level (stretch detect)
//            scl_out    out 1      SCL drive level (1 = release)
//            phase      out 2      current quarter
//            phase_tick out 1      strobe on last cycle of each quarter
//            busy       out 1      running or completing the current period
//            stretching out 1      quarter held by a slave stretch
// Options  : I2C_CLK_STRETCH_EN - enables slave clock stretching via a
//            synchronised scl_in; otherwise scl_in is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_scl_timing_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIV_MODE0 = DEF_DIV_MODE0,
  parameter int unsigned DIV_MODE1 = DEF_DIV_MODE1,
  parameter int unsigned DIV_MODE2 = DEF_DIV_MODE2,
  parameter int unsigned DIV_MODE3 = DEF_DIV_MODE3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       freq_mode,
  input  logic             div_load,
  input  logic             div_clr,
  input  logic [CNT_W-1:0] div_value,
  input  logic             scl_in,
  output logic             scl_out,
  output logic [1:0]       phase,
  output logic             phase_tick,
  output logic             busy,
  output logic             stretching
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [1:0]       phase_q,    phase_d;
  logic             scl_q,      scl_d;
  logic [CNT_W-1:0] cur_div_q,  cur_div_d;
  logic [CNT_W-1:0] ovr_val_q,  ovr_val_d;
  logic             ovr_pend_q, ovr_pend_d;
  logic             ovr_act_q,  ovr_act_d;

  logic             running;
  logic             hold;
  logic             tick;
  logic             boundary;
  logic [CNT_W-1:0] tbl_div;
  logic [CNT_W-1:0] load_val;
  logic             scl_sync;

`ifdef I2C_CLK_STRETCH_EN
  i2c_sync2 u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .d     (scl_in),
    .q     (scl_sync)
  );
`else
  // Stretch detection disabled: the bus always reads as released.
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign scl_sync      = 1'b1;
`endif

  // Table lookup for the selected bus frequency
  always_comb begin
    tbl_div = CNT_W'(DIV_MODE0);
    case (freq_mode)
      FREQ_MODE_100K: tbl_div = CNT_W'(DIV_MODE0);
      FREQ_MODE_400K: tbl_div = CNT_W'(DIV_MODE1);
      FREQ_MODE_1M:   tbl_div = CNT_W'(DIV_MODE2);
      FREQ_MODE_3M:   tbl_div = CNT_W'(DIV_MODE3);
      default:        tbl_div = CNT_W'(DIV_MODE0);
    endcase
  end

  // A zero reload would give a 1-cycle quarter; keep the minimum at 2 cycles.
  assign load_val = (div_value == '0) ? CNT_ONE : div_value;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    scl_d      = scl_q;
    cur_div_d  = cur_div_q;
    ovr_val_d  = ovr_val_q;
    ovr_pend_d = ovr_pend_q;
    ovr_act_d  = ovr_act_q;

    running  = (state_q != ST_IDLE);
    // While the slave holds SCL low in the first high quarter, the quarter
    // restarts so the high time is measured from the observed rise.
    hold     = running && (phase_q == PHASE_HIGH0) && !scl_sync;
    tick     = running && !hold && (cnt_q == '0);
    boundary = tick && (phase_q == PHASE_HIGH1);

    // Divider selection happens only at the period boundary; the old
    // override state is used here, new pulses affect the next boundary.
    if (boundary) begin
      cur_div_d = (ovr_pend_q || ovr_act_q) ? ovr_val_q : tbl_div;
      if (ovr_pend_q) begin
        ovr_act_d  = 1'b1;
        ovr_pend_d = 1'b0;
      end
    end

    if (div_load) begin
      ovr_pend_d = 1'b1;
      ovr_val_d  = load_val;
    end else if (div_clr) begin
      ovr_pend_d = 1'b0;
      ovr_act_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          cnt_d   = cur_div_q;
          phase_d = PHASE_LOW0;
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (enable)        state_d = ST_RUN;
        else if (boundary) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (running) begin
      if (hold) begin
        cnt_d = cur_div_q;
      end else if (tick) begin
        cnt_d   = cur_div_d;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    // SCL follows the upper phase bit while running and is released in IDLE;
    // registering it puts the edge on the cycle after the 1->2 / 3->0 tick.
    scl_d = (state_d == ST_IDLE) ? 1'b1 : phase_d[1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      phase_q    <= PHASE_LOW0;
      scl_q      <= 1'b1;
      cur_div_q  <= CNT_W'(DIV_MODE0);
      ovr_val_q  <= CNT_ONE;
      ovr_pend_q <= 1'b0;
      ovr_act_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      scl_q      <= scl_d;
      cur_div_q  <= cur_div_d;
      ovr_val_q  <= ovr_val_d;
      ovr_pend_q <= ovr_pend_d;
      ovr_act_q  <= ovr_act_d;
    end
  end

  assign scl_out    = scl_q;
  assign phase      = phase_q;
  assign phase_tick = tick;
  assign busy       = running;
  assign stretching = hold;

endmodule : i2c_scl_timing_gen

`default_nettype wire

// File: tb/tb_i2c_scl_timing_gen.sv
// ============================================================================
// Module   : tb_i2c_scl_timing_gen
// Purpose  : Self-checking bench for i2c_scl_timing_gen. A cycle model built
//            from quarter lengths and period boundaries predicts every output
//            each cycle; directed scenarios add measured period checks.
// Options  : I2C_CLK_STRETCH_EN - adds the slave-stretch scenario and models
//            the synchroniser delay seen at each SCL rise.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_scl_timing_gen;

  localparam int CNT_W = 16;
`ifdef I2C_CLK_STRETCH_EN
  localparam int XTRA = 2;   // SCL rise takes two sync cycles to be observed
`else
  localparam int XTRA = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [1:0]       freq_mode = 2'b00;
  logic             div_load = 1'b0;
  logic             div_clr = 1'b0;
  logic [CNT_W-1:0] div_value = '0;
  logic             slave_hold = 1'b0;
  logic             scl_rand = 1'b1;
  logic             scl_in;
  logic             scl_out;
  logic [1:0]       phase;
  logic             phase_tick;
  logic             busy;
  logic             stretching;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef I2C_CLK_STRETCH_EN
  assign scl_in = scl_out & ~slave_hold;   // open-drain wired-AND bus
`else
  assign scl_in = scl_rand;                // must be ignored
`endif

  i2c_scl_timing_gen #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .freq_mode  (freq_mode),
    .div_load   (div_load),
    .div_clr    (div_clr),
    .div_value  (div_value),
    .scl_in     (scl_in),
    .scl_out    (scl_out),
    .phase      (phase),
    .phase_tick (phase_tick),
    .busy       (busy),
    .stretching (stretching)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_el counts cycles elapsed in the current quarter; the quarter ends when
  // it reaches m_cur (quarter length m_cur+1).
  int m_cur = 124, m_el = 0, m_phase = 0, m_oval = 1;
  bit m_busy = 0, m_fin = 0, m_pend = 0, m_act = 0, m_s1 = 1, m_s2 = 1;

  function automatic int tbl(input logic [1:0] fm);
    case (fm)
      2'b00:   return 124;
      2'b01:   return 30;
      2'b10:   return 11;
      default: return 3;
    endcase
  endfunction

  function automatic bit m_stall();
    return (XTRA != 0) && m_busy && (m_phase == 2) && !m_s2;
  endfunction

  function automatic bit m_tick();
    return m_busy && !m_stall() && (m_el == m_cur);
  endfunction

  function automatic bit m_scl();
    return m_busy ? (m_phase >= 2) : 1'b1;
  endfunction

  always @(posedge clk) begin
    bit tk, bnd, st, smp;
    if (!reset) begin
      m_busy = 0; m_fin = 0; m_phase = 0; m_el = 0; m_cur = 124;
      m_pend = 0; m_act = 0; m_oval = 1; m_s1 = 1; m_s2 = 1;
    end else begin
      st  = m_stall();
      tk  = m_tick();
      bnd = tk && (m_phase == 3);
      smp = m_scl() & ~slave_hold;
      if (bnd) begin
        m_cur = (m_pend || m_act) ? m_oval : tbl(freq_mode);
        if (m_pend) begin m_act = 1; m_pend = 0; end
      end
      if (div_load) begin
        m_pend = 1;
        m_oval = (div_value == 0) ? 1 : int'(div_value);
      end else if (div_clr) begin
        m_pend = 0; m_act = 0;
      end
      if (!m_busy) begin
        if (enable) begin m_busy = 1; m_phase = 0; m_el = 0; end
      end else begin
        if (st)      m_el = 0;
        else if (tk) begin m_el = 0; m_phase = (m_phase + 1) % 4; end
        else         m_el++;
        if (m_fin) begin
          if (enable)   m_fin = 0;
          else if (bnd) begin m_busy = 0; m_fin = 0; m_phase = 0; end
        end else if (!enable) begin
          m_fin = 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = smp;
    end
  end

  always @(negedge clk) begin
    check_val("busy",       busy,       32'(m_busy));
    check_val("phase",      phase,      32'(m_phase));
    check_val("scl_out",    scl_out,    32'(m_scl()));
    check_val("phase_tick", phase_tick, 32'(m_tick()));
    check_val("stretching", stretching, 32'(m_stall()));
  end

  // ---------------- bounded wait / measurement helpers ----------------
  task automatic wait_phase(input int p);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (busy && phase == 2'(p)) ok = 1;
    end
    check_val("wait_phase", 32'(ok), 32'd1);
  endtask

  task automatic wait_tick(input bit need_boundary);
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (phase_tick && (!need_boundary || phase == 2'd3)) ok = 1;
    end
    check_val("wait_tick", 32'(ok), 32'd1);
  endtask

  task automatic measure(input bit need_boundary, output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (phase_tick && (!need_boundary || phase == 2'd3)) ok = 1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    int n;
    bit ok;

    // Reset
    repeat (3) @(negedge clk);
    check_val("rst_scl",   32'(scl_out),    32'd1);
    check_val("rst_phase", 32'(phase),      32'd0);
    check_val("rst_busy",  32'(busy),       32'd0);
    check_val("rst_tick",  32'(phase_tick), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Mode 00: quarter of 125 cycles
    enable = 1'b1;
    wait_tick(1'b0);
    measure(1'b0, g);
    check_val("quarter_m0", 32'(g), 32'd125);

    // Switch to mode 11 late in phase 1: current period untouched, next is 16
    freq_mode = 2'b11;
    wait_tick(1'b1);
    measure(1'b1, g);
    check_val("period_m3", 32'(g), 32'(16 + XTRA));

    // Override with div_value 0 (clamped to 1) loaded in phase 2
    wait_phase(2);
    div_value = '0;
    div_load  = 1'b1;
    @(negedge clk);
    div_load  = 1'b0;
    div_value = CNT_W'($urandom);
    wait_tick(1'b1);
    measure(1'b1, g);
    check_val("period_clamp", 32'(g), 32'(8 + XTRA));
    div_clr = 1'b1;
    @(negedge clk);
    div_clr = 1'b0;
    wait_tick(1'b1);
    measure(1'b1, g);
    check_val("period_clr", 32'(g), 32'(16 + XTRA));

    // Enable drop in phase 1 at mode 01: finish through the phase 3 tick
    freq_mode = 2'b01;
    wait_tick(1'b1);
    wait_phase(1);
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 1000 && busy; i++) begin
      @(negedge clk);
      if (phase_tick) n++;
    end
    check_val("fin_ticks", 32'(n), 32'd3);
    check_val("fin_scl",   32'(scl_out), 32'd1);
    repeat (50) @(negedge clk);

    // Reset in phase 2 while running fast: divider returns to mode 00 value
    freq_mode = 2'b11;
    enable    = 1'b1;
    wait_tick(1'b1);
    wait_phase(2);
    reset = 1'b0;
    @(negedge clk);
    check_val("rstm_scl",   32'(scl_out), 32'd1);
    check_val("rstm_phase", 32'(phase),   32'd0);
    check_val("rstm_busy",  32'(busy),    32'd0);
    reset = 1'b1;
    wait_tick(1'b0);
    measure(1'b0, g);
    check_val("post_rst_gap", 32'(g), 32'd125);

`ifdef I2C_CLK_STRETCH_EN
    // Slave holds SCL low for 300 cycles into phase 2 at mode 00
    freq_mode = 2'b00;
    wait_tick(1'b1);
    wait_phase(1);
    slave_hold = 1'b1;
    wait_phase(2);
    repeat (300) @(negedge clk);
    check_val("stretch_on",    32'(stretching), 32'd1);
    check_val("stretch_phase", 32'(phase),      32'd2);
    slave_hold = 1'b0;
    ok = 0;
    n  = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (phase_tick) ok = 1;
    end
    check_val("stretch_release", 32'(n), 32'(125 + XTRA));
`else
    ok = 1;
    check_val("stretch_off", 32'(stretching), 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      div_load = 1'b0;
      div_clr  = 1'b0;
      reset    = 1'b1;
      if ($urandom_range(0, 63) == 0)  enable = ~enable;
      if ($urandom_range(0, 31) == 0)  freq_mode = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 39) == 0) begin
        div_load  = 1'b1;
        div_value = CNT_W'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 59) == 0)  div_clr = 1'b1;
      if ($urandom_range(0, 799) == 0) reset = 1'b0;
      scl_rand = 1'($urandom);
    end
    @(negedge clk);
    div_load = 1'b0;
    div_clr  = 1'b0;
    reset    = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_i2c_scl_timing_gen

`default_nettype wire
